riscv_lsu: RTL and testbench

- Load/store unit directly downstream of the execute ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Performs one data-memory transaction per load/store over a req/ready handshake. Applies RV32I byte/half/word lane steering and sign/zero extension.
- Stalls the single-cycle core while the access is outstanding.

---
 rtl/riscv_lsu_pkg.sv | 32 +++
 rtl/riscv_lsu_align.sv | 53 +++++
 rtl/riscv_lsu.sv | 152 +++++++++++++++
 tb/tb_riscv_lsu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// byte-strobe patterns and the decode-time fault predicates.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  function automatic logic f3_bad(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return !(f3 inside {F3_B, F3_H, F3_W});
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane steering: store strobe/replication from the live
// instruction, load extraction/extension from the captured access fields.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_rep,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wstrb     = STRB_W;
    wdata_rep = wdata;
    case (st_funct3)
      F3_B: begin
        wstrb     = STRB_B << st_off;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        wstrb     = STRB_H << {st_off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = mem_rdata[{ld_off, 3'b000} +: 8];
  assign lane_h = mem_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    case (ld_funct3)
      F3_B:    ld_data = DATA_W'($signed(lane_b));
      F3_H:    ld_data = DATA_W'($signed(lane_h));
      F3_W:    ld_data = mem_rdata;
      F3_BU:   ld_data = DATA_W'(lane_b);
      F3_HU:   ld_data = DATA_W'(lane_h);
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one req/ready memory transaction per load/store,
// stalling the core while BUSY. Optional bus timeout via `LSU_TIMEOUT_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              illegal,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  lsu_state_t        state, state_nx;
  logic              start, illegal_c, mis_c, clean_start;
  logic [2:0]        funct3_p1;
  logic [1:0]        off_p1;
  logic [3:0]        wstrb_c;
  logic [DATA_W-1:0] wdata_c, ld_ext;
  logic              timeout_hit;

  assign start       = ex_valid & (mem_read | mem_write);
  assign illegal_c   = (mem_read & mem_write) | f3_bad(mem_read, funct3);
  assign mis_c       = ~illegal_c & f3_misaligned(funct3, addr[1:0]);
  assign clean_start = start & ~illegal_c & ~mis_c;

  riscv_lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .wdata     (wdata),
    .wstrb     (wstrb_c),
    .wdata_rep (wdata_c),
    .ld_funct3 (funct3_p1),
    .ld_off    (off_p1),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_p1;

  // The wait that brings the count up to TIMEOUT_CYCLES ends the access.
  assign timeout_hit = (state == BUSY) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_p1   <= 1'b0;
    end else if (state == IDLE && clean_start) begin
      wait_cnt <= '0;
      err_p1   <= 1'b0;
    end else if (state == BUSY && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) err_p1 <= 1'b1;
    end
  end

  assign bus_err = (state == DONE) && err_p1;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clean_start) state_nx = BUSY;
      BUSY:    if (mem_ready || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    mem_req    = 1'b0;
    load_valid = 1'b0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        illegal    = start & illegal_c;
        misaligned = start & mis_c;
        stall      = clean_start;
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      DONE:    load_valid = ~mem_we;
      default: ;
    endcase
  end

  // Access capture at issue; load result captured on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_p1 <= '0;
      off_p1    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= STRB_NONE;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && clean_start) begin
        funct3_p1 <= funct3;
        off_p1    <= addr[1:0];
        mem_we    <= mem_write;
        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_wstrb <= mem_write ? wstrb_c : STRB_NONE;
        mem_wdata <= wdata_c;
      end
      if (state == BUSY && !mem_we) begin
        if (mem_ready)        rdata <= ld_ext;
        else if (timeout_hit) rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases plus randomized accesses
// scored against a lane/extension model built from plain arithmetic.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, load_valid, misaligned, illegal, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef LSU_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_run = 0;
  int n_fail = 0;

  int          obs_stall, obs_req, obs_lv, obs_mis, obs_ill;
  logic [31:0] obs_addr, obs_wd, obs_rdata;
  logic [3:0]  obs_strb;
  logic        obs_we, obs_stable;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  riscv_lsu #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef LSU_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .load_valid(load_valid), .rdata(rdata),
    .misaligned(misaligned), .illegal(illegal), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef LSU_TIMEOUT_EN
    ,
    .bus_err(bus_err)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_fault(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    bit ill, mis;
    int sz = f3 % 4;
    ill = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (!rd && wr && f3 > 2);
    mis = !ill && ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
    return {ill, mis};
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int off = a % 4;
    longint v;
    case (f3)
      3'd0, 3'd4: begin
        v = (d >> (8 * off)) & 'hFF;
        if (f3 == 0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (d >> (16 * (off / 2))) & 'hFFFF;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(logic [2:0] f3, logic [31:0] a);
    int off = a % 4;
    if (f3 == 0) return 4'(1 << off);
    if (f3 == 1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wrep(logic [2:0] f3, logic [31:0] d);
    if (f3 == 0) return (d % 256) * 32'h0101_0101;
    if (f3 == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Drives one instruction through the unit and records what the DUT did.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] md, input int waits, input bit idle_after);
    logic [1:0] flt = model_fault(rd, wr, f3, a);
    obs_stall = 0; obs_req = 0; obs_lv = 0; obs_mis = 0; obs_ill = 0; obs_stable = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    obs_stall += stall; obs_req += mem_req; obs_lv += load_valid;
    obs_mis += misaligned; obs_ill += illegal;
    if (flt == 2'b00) begin
      for (int w = 0; w <= waits; w++) begin
        @(posedge clk); #1;
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? md : $urandom;
        @(negedge clk);
        obs_stall += stall; obs_req += mem_req; obs_lv += load_valid;
        obs_mis += misaligned; obs_ill += illegal;
        if (w == 0) begin
          obs_addr = mem_addr; obs_we = mem_we; obs_strb = mem_wstrb; obs_wd = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {obs_addr, obs_we, obs_strb, obs_wd}) begin
          obs_stable = 1'b0;
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      obs_stall += stall; obs_req += mem_req; obs_lv += load_valid;
    end
    obs_rdata = rdata;
    if (idle_after || flt != 2'b00) begin
      @(posedge clk); #1;
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      obs_stall += stall; obs_req += mem_req; obs_lv += load_valid;
      obs_mis += misaligned; obs_ill += illegal;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_run++;
    if ({stall, load_valid, rdata, misaligned, illegal, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got stall=%b req=%b rdata=%h mem_addr=%h, required all zero",
                         stall, mem_req, rdata, mem_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_rdata = '0;
  endtask

  task automatic test_directed();
    // LB at byte 3, two wait states
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 2, 1'b1);
    model_rdata = 32'hFFFF_FF80;
    n_run++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL lb_mem_addr: got %h required 00000100", obs_addr); end
    n_run++; if (obs_strb !== 4'b0000) begin n_fail++; $display("FAIL lb_wstrb: got %b required 0000", obs_strb); end
    n_run++; if (obs_stall != 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d required 4", obs_stall); end
    n_run++; if (obs_lv != 1) begin n_fail++; $display("FAIL lb_load_valid: got %0d pulses required 1", obs_lv); end
    n_run++; if (obs_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h required ffffff80", obs_rdata); end
    // LHU upper half, immediate ready
    run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0000, 0, 1'b1);
    model_rdata = 32'h0000_BEEF;
    n_run++; if (obs_rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_rdata: got %h required 0000beef", obs_rdata); end
    n_run++; if (obs_stall != 2) begin n_fail++; $display("FAIL lhu_stall_cycles: got %0d required 2", obs_stall); end
    // SH upper half
    run_access(1'b0, 1'b1, 3'b001, 32'h006, 32'h1234_ABCD, 32'h0, 1, 1'b1);
    n_run++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL sh_mem_we: got %b required 1", obs_we); end
    n_run++; if (obs_strb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b required 1100", obs_strb); end
    n_run++; if (obs_wd !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h required abcdabcd", obs_wd); end
    n_run++; if (obs_lv != 0) begin n_fail++; $display("FAIL sh_load_valid: got %0d pulses required 0", obs_lv); end
    n_run++; if (obs_rdata !== model_rdata) begin n_fail++; $display("FAIL sh_rdata_held: got %h required %h", obs_rdata, model_rdata); end
    // LW misaligned
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1);
    n_run++; if (obs_mis != 1) begin n_fail++; $display("FAIL lw_misaligned: got %0d pulses required 1", obs_mis); end
    n_run++; if (obs_req != 0 || obs_stall != 0) begin n_fail++; $display("FAIL lw_mis_no_req: got req=%0d stall=%0d required 0/0", obs_req, obs_stall); end
    // read&write together: illegal beats misaligned
    run_access(1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1);
    n_run++; if (obs_ill != 1 || obs_mis != 0) begin n_fail++; $display("FAIL rw_illegal: got ill=%0d mis=%0d required 1/0", obs_ill, obs_mis); end
    n_run++; if (obs_req != 0) begin n_fail++; $display("FAIL rw_no_req: got %0d required 0", obs_req); end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, wd, md;
    logic        rd, wr;
    logic [1:0]  flt;
    int          waits, r;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd && !wr) f3 = (r % 2 == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
      else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << (f3 % 4)) - 1);
      wd = $urandom; md = $urandom;
      waits = $urandom_range(0, 3);
      flt = model_fault(rd, wr, f3, a);
      run_access(rd, wr, f3, a, wd, md, waits, bit'($urandom_range(0, 1)));
      if (flt == 2'b00 && rd) model_rdata = model_load(f3, a, md);
      n_run++; if (obs_ill != int'(flt[1])) begin n_fail++; $display("FAIL rnd%0d illegal: got %0d required %0d", i, obs_ill, flt[1]); end
      n_run++; if (obs_mis != int'(flt[0])) begin n_fail++; $display("FAIL rnd%0d misaligned: got %0d required %0d", i, obs_mis, flt[0]); end
      n_run++; if (obs_stall != (flt == 0 ? waits + 2 : 0)) begin n_fail++; $display("FAIL rnd%0d stall_cycles: got %0d required %0d", i, obs_stall, flt == 0 ? waits + 2 : 0); end
      n_run++; if (obs_req != (flt == 0 ? waits + 1 : 0)) begin n_fail++; $display("FAIL rnd%0d req_cycles: got %0d required %0d", i, obs_req, flt == 0 ? waits + 1 : 0); end
      n_run++; if (obs_lv != ((flt == 0 && rd) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d load_valid: got %0d required %0d", i, obs_lv, (flt == 0 && rd) ? 1 : 0); end
      n_run++; if (obs_rdata !== model_rdata) begin n_fail++; $display("FAIL rnd%0d rdata: got %h required %h", i, obs_rdata, model_rdata); end
      if (flt == 2'b00) begin
        n_run++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== wr || !obs_stable) begin
          n_fail++; $display("FAIL rnd%0d bus_fields: got addr=%h we=%b stable=%b required addr=%h we=%b stable=1",
                             i, obs_addr, obs_we, obs_stable, {a[31:2], 2'b00}, wr);
        end
        n_run++; if (obs_strb !== (wr ? model_strb(f3, a) : 4'b0000)) begin n_fail++; $display("FAIL rnd%0d wstrb: got %b required %b", i, obs_strb, wr ? model_strb(f3, a) : 4'b0000); end
        if (wr) begin
          n_run++; if (obs_wd !== model_wrep(f3, wd)) begin n_fail++; $display("FAIL rnd%0d wdata: got %h required %h", i, obs_wd, model_wrep(f3, wd)); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] a, md;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 6; i++) begin
      f3 = ld_f3[$urandom_range(0, 4)];
      a  = $urandom & ~((32'd1 << (f3 % 4)) - 1);
      md = $urandom;
      run_access(1'b1, 1'b0, f3, a, 32'h0, md, $urandom_range(0, 1), i == 5);
      model_rdata = model_load(f3, a, md);
      n_run++; if (obs_lv != 1 || obs_rdata !== model_rdata) begin
        n_fail++; $display("FAIL b2b%0d load: got lv=%0d rdata=%h required lv=1 rdata=%h", i, obs_lv, obs_rdata, model_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got mem_req=%b required 1", mem_req); end
    #2;
    ex_valid = 1'b0; mem_read = 1'b0; rst_n = 1'b0;
    #1;
    n_run++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got req=%b stall=%b required 0/0", mem_req, stall); end
    @(posedge clk); #1 rst_n = 1'b1;
    model_rdata = '0;
    @(negedge clk);
    n_run++; if ({stall, load_valid, rdata, misaligned, illegal, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got rdata=%h mem_addr=%h req=%b, required all zero", rdata, mem_addr, mem_req);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h1357_9BDF, 0, 1'b1);
    model_rdata = 32'h1357_9BDF;
    n_run++; if (obs_stall != 2 || obs_rdata !== model_rdata) begin
      n_fail++; $display("FAIL rst_mid_recover: got stall=%0d rdata=%h required 2 %h", obs_stall, obs_rdata, model_rdata);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int busy = 0;
    logic done_seen = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h20; mem_ready = 1'b0;
    for (int c = 0; c < 12 && !done_seen; c++) begin
      @(negedge clk);
      if (mem_req) busy++;
      if (load_valid) begin
        done_seen = 1'b1;
        n_run++; if (bus_err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_done: got bus_err=%b rdata=%h required 1 00000000", bus_err, rdata); end
      end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; mem_read = 1'b0;
    model_rdata = '0;
    n_run++; if (!done_seen || busy != 4) begin n_fail++; $display("FAIL timeout_wait: got done=%b busy=%0d required 1 4", done_seen, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
